// File: rtl/game_timer_ctrl_if.sv
// Control/status bundle for the game countdown timer.
// The master drives the one-cycle command pulses; the slave returns the timer status.
interface game_timer_ctrl_if;
  logic        i_start;
  logic        i_pause;
  logic        i_abort;
  logic        i_penalty;
  logic [20:0] o_time_left;
  logic [1:0]  o_state;
  logic        o_running;
  logic        o_warn;
  logic        o_tick;
  logic        o_game_over;

  modport master (
    output i_start, i_pause, i_abort, i_penalty,
    input  o_time_left, o_state, o_running, o_warn, o_tick, o_game_over
  );

  modport slave (
    input  i_start, i_pause, i_abort, i_penalty,
    output o_time_left, o_state, o_running, o_warn, o_tick, o_game_over
  );
endinterface

// File: rtl/game_timer_ctrl.sv
// Game countdown timer: a prescaled tick countdown with pause/resume, penalties and expiry.
// All status outputs are registered and change together on the clock edge.
module game_timer_ctrl #(
  parameter int unsigned TICK_DIV = 5000,
  parameter int unsigned LIMIT    = 1800000,
  parameter int unsigned PENALTY  = 10000,
  parameter int unsigned WARN     = 100000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  game_timer_ctrl_if.slave io_tmr
);

  localparam int unsigned TW = 21;
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TL_LIMIT = TW'(LIMIT);
  localparam logic [PW-1:0] PS_LAST  = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUN     = 2'b01,
    ST_PAUSE   = 2'b10,
    ST_EXPIRED = 2'b11
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [TW-1:0] r_time_left;
  logic [TW-1:0] w_time_left_nxt;
  logic [PW-1:0] r_presc;
  logic [PW-1:0] w_presc_nxt;
  logic          r_running;
  logic          w_running_nxt;
  logic          r_warn;
  logic          w_warn_nxt;
  logic          r_tick;
  logic          w_tick_nxt;
  logic          r_game_over;
  logic          w_game_over_nxt;

  logic          w_tick_en;
  logic [TW-1:0] w_pen_result;

  // Tick strobe and saturating penalty result, both from current registered state.
  always_comb begin
    w_tick_en    = (r_state == ST_RUN) && (r_presc == PS_LAST);
    w_pen_result = '0;
    if (32'(r_time_left) > PENALTY) begin
      w_pen_result = r_time_left - TW'(PENALTY);
    end
  end

  // State register and all registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_time_left <= TL_LIMIT;
      r_presc     <= '0;
      r_running   <= 1'b0;
      r_warn      <= 1'b0;
      r_tick      <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_time_left <= w_time_left_nxt;
      r_presc     <= w_presc_nxt;
      r_running   <= w_running_nxt;
      r_warn      <= w_warn_nxt;
      r_tick      <= w_tick_nxt;
      r_game_over <= w_game_over_nxt;
    end
  end

  // Next-state logic: abort wins outright; penalty masks a coincident tick, but
  // pause/start still steer the state unless the new time has reached zero.
  always_comb begin
    w_state_nxt     = r_state;
    w_time_left_nxt = r_time_left;
    w_tick_nxt      = 1'b0;
    w_game_over_nxt = 1'b0;

    if (io_tmr.i_abort) begin
      w_state_nxt     = ST_IDLE;
      w_time_left_nxt = TL_LIMIT;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_time_left_nxt = TL_LIMIT;
          if (io_tmr.i_start) begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_RUN, ST_PAUSE: begin
          if (io_tmr.i_penalty) begin
            w_time_left_nxt = w_pen_result;
          end else if (w_tick_en) begin
            w_time_left_nxt = r_time_left - TW'(1);
            w_tick_nxt      = 1'b1;
          end

          if (w_time_left_nxt == '0) begin
            w_state_nxt     = ST_EXPIRED;
            w_game_over_nxt = 1'b1;
          end else if ((r_state == ST_RUN) && io_tmr.i_pause) begin
            w_state_nxt = ST_PAUSE;
          end else if ((r_state == ST_PAUSE) && io_tmr.i_start) begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_EXPIRED: begin
          w_time_left_nxt = '0;
        end
        default: begin
          w_state_nxt     = ST_IDLE;
          w_time_left_nxt = TL_LIMIT;
        end
      endcase
    end
  end

  // Prescaler counts only while running, holds through a pause, clears otherwise.
  always_comb begin
    w_presc_nxt = r_presc;
    if ((w_state_nxt == ST_IDLE) || (w_state_nxt == ST_EXPIRED)) begin
      w_presc_nxt = '0;
    end else if (r_state == ST_RUN) begin
      w_presc_nxt = w_tick_en ? '0 : r_presc + PW'(1);
    end
  end

  // Status flags derived from the values about to be registered.
  always_comb begin
    w_running_nxt = (w_state_nxt == ST_RUN);
    w_warn_nxt    = w_running_nxt && (w_time_left_nxt != '0) &&
                    (32'(w_time_left_nxt) <= WARN);
  end

  assign io_tmr.o_time_left = r_time_left;
  assign io_tmr.o_state     = r_state;
  assign io_tmr.o_running   = r_running;
  assign io_tmr.o_warn      = r_warn;
  assign io_tmr.o_tick      = r_tick;
  assign io_tmr.o_game_over = r_game_over;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Self-checking bench for game_timer_ctrl: directed scenarios plus a randomized run
// checked against a cycle-level behavioural model of the timer rules.
module tb_game_timer_ctrl;

  localparam int TICK_DIV = 4;
  localparam int LIMIT    = 10;
  localparam int PENALTY  = 3;
  localparam int WARN     = 2;

  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_PAUSE = 2;
  localparam int S_EXP  = 3;

  logic clk;
  logic rst_n;

  game_timer_ctrl_if bus ();

  game_timer_ctrl #(
    .TICK_DIV (TICK_DIV),
    .LIMIT    (LIMIT),
    .PENALTY  (PENALTY),
    .WARN     (WARN)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_tmr  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model: game phase, remaining ticks, cycles elapsed in current tick period.
  int m_state = S_IDLE;
  int m_tl    = LIMIT;
  int m_cnt   = 0;
  bit m_tick  = 1'b0;
  bit m_go    = 1'b0;

  task automatic model_step(input bit rst, input bit st, input bit pa,
                            input bit ab, input bit pe);
    bit fire;
    m_tick = 1'b0;
    m_go   = 1'b0;
    if (!rst || ab) begin
      m_state = S_IDLE;
      m_tl    = LIMIT;
      m_cnt   = 0;
      return;
    end
    fire = (m_state == S_RUN) && (m_cnt == TICK_DIV - 1);
    if (m_state == S_RUN) m_cnt = (m_cnt + 1) % TICK_DIV;
    if (m_state == S_IDLE) begin
      if (st) m_state = S_RUN;
    end else if (m_state == S_RUN || m_state == S_PAUSE) begin
      if (pe) m_tl = (m_tl > PENALTY) ? m_tl - PENALTY : 0;
      else if (fire) begin
        m_tl   = m_tl - 1;
        m_tick = 1'b1;
      end
      if (m_tl == 0) begin
        m_state = S_EXP;
        m_go    = 1'b1;
        m_cnt   = 0;
      end else if (m_state == S_RUN && pa) m_state = S_PAUSE;
      else if (m_state == S_PAUSE && st) m_state = S_RUN;
    end
  endtask

  task automatic drive(input bit rst, input bit st, input bit pa,
                       input bit ab, input bit pe);
    rst_n         = rst;
    bus.i_start   = st;
    bus.i_pause   = pa;
    bus.i_abort   = ab;
    bus.i_penalty = pe;
    @(posedge clk);
    model_step(rst, st, pa, ab, pe);
    #1;
    rst_n         = 1'b1;
    bus.i_start   = 1'b0;
    bus.i_pause   = 1'b0;
    bus.i_abort   = 1'b0;
    bus.i_penalty = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checks++; if (bus.o_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", bus.o_state); end
    checks++; if (bus.o_time_left !== 21'd10) begin errors++; $display("FAIL reset_time_left: got %0d want 10", bus.o_time_left); end
    checks++; if (bus.o_running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b want 0", bus.o_running); end
    checks++; if (bus.o_warn !== 1'b0) begin errors++; $display("FAIL reset_warn: got %b want 0", bus.o_warn); end
    checks++; if (bus.o_tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b want 0", bus.o_tick); end
    checks++; if (bus.o_game_over !== 1'b0) begin errors++; $display("FAIL reset_game_over: got %b want 0", bus.o_game_over); end
  endtask

  task automatic test_full_countdown;
    int exp_tl;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.o_state !== 2'd1 || bus.o_running !== 1'b1) begin errors++; $display("FAIL cd_start: state %0d running %b want 1/1", bus.o_state, bus.o_running); end
    for (int i = 1; i <= 40; i++) begin
      idle(1);
      exp_tl = LIMIT - i / TICK_DIV;
      checks++; if (bus.o_time_left !== 21'(exp_tl)) begin errors++; $display("FAIL cd_time_left[%0d]: got %0d want %0d", i, bus.o_time_left, exp_tl); end
      checks++; if (bus.o_tick !== 1'((i % TICK_DIV) == 0)) begin errors++; $display("FAIL cd_tick[%0d]: got %b want %b", i, bus.o_tick, (i % TICK_DIV) == 0); end
      checks++; if (bus.o_warn !== 1'(exp_tl > 0 && exp_tl <= WARN)) begin errors++; $display("FAIL cd_warn[%0d]: got %b", i, bus.o_warn); end
      checks++; if (bus.o_game_over !== 1'(i == 40)) begin errors++; $display("FAIL cd_game_over[%0d]: got %b want %b", i, bus.o_game_over, i == 40); end
    end
    checks++; if (bus.o_state !== 2'd3 || bus.o_running !== 1'b0) begin errors++; $display("FAIL cd_expired: state %0d running %b want 3/0", bus.o_state, bus.o_running); end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    checks++; if (bus.o_state !== 2'd3 || bus.o_time_left !== 21'd0 || bus.o_game_over !== 1'b0) begin errors++; $display("FAIL cd_expired_hold: state %0d tl %0d go %b want 3/0/0", bus.o_state, bus.o_time_left, bus.o_game_over); end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (bus.o_state !== 2'd0 || bus.o_time_left !== 21'd10) begin errors++; $display("FAIL cd_abort: state %0d tl %0d want 0/10", bus.o_state, bus.o_time_left); end
  endtask

  task automatic test_pause_resume;
    int d, e, bad, gap;
    bit seen;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(8);
    checks++; if (bus.o_time_left !== 21'd8) begin errors++; $display("FAIL pr_two_ticks: got %0d want 8", bus.o_time_left); end
    d = int'($urandom_range(0, 2));
    e = d + 1;
    idle(d);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (bus.o_state !== 2'd2 || bus.o_running !== 1'b0) begin errors++; $display("FAIL pr_paused: state %0d running %b want 2/0", bus.o_state, bus.o_running); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, (i == 10), 1'b0, 1'b0);
      if (bus.o_time_left !== 21'd8 || bus.o_state !== 2'd2 || bus.o_tick !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL pr_hold: %0d cycles changed during pause, want 0", bad); end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.o_state !== 2'd1) begin errors++; $display("FAIL pr_resume: state %0d want 1", bus.o_state); end
    seen = 1'b0;
    gap  = 0;
    for (int i = 1; i <= 10 && !seen; i++) begin
      idle(1);
      if (bus.o_tick === 1'b1) begin seen = 1'b1; gap = i; end
    end
    checks++; if (!seen || gap != TICK_DIV - e) begin errors++; $display("FAIL pr_next_tick: seen %b after %0d cycles want %0d", seen, gap, TICK_DIV - e); end
    checks++; if (bus.o_time_left !== 21'd7) begin errors++; $display("FAIL pr_after_tick: got %0d want 7", bus.o_time_left); end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_penalty_expire;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    checks++; if (bus.o_state !== 2'd0 || bus.o_time_left !== 21'd10) begin errors++; $display("FAIL pe_idle_ignore: state %0d tl %0d want 0/10", bus.o_state, bus.o_time_left); end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(32);
    checks++; if (bus.o_time_left !== 21'd2) begin errors++; $display("FAIL pe_at_two: got %0d want 2", bus.o_time_left); end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (bus.o_time_left !== 21'd0 || bus.o_state !== 2'd3 || bus.o_game_over !== 1'b1) begin errors++; $display("FAIL pe_expire: tl %0d state %0d go %b want 0/3/1", bus.o_time_left, bus.o_state, bus.o_game_over); end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    checks++; if (bus.o_time_left !== 21'd0 || bus.o_state !== 2'd3 || bus.o_game_over !== 1'b0) begin errors++; $display("FAIL pe_expired_ignore: tl %0d state %0d go %b want 0/3/0", bus.o_time_left, bus.o_state, bus.o_game_over); end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (bus.o_time_left !== 21'd1 || bus.o_state !== 2'd2) begin errors++; $display("FAIL pe_pause_sub: tl %0d state %0d want 1/2", bus.o_time_left, bus.o_state); end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (bus.o_time_left !== 21'd0 || bus.o_state !== 2'd3 || bus.o_game_over !== 1'b1) begin errors++; $display("FAIL pe_pause_expire: tl %0d state %0d go %b want 0/3/1", bus.o_time_left, bus.o_state, bus.o_game_over); end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_penalty_tick;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(15);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (bus.o_time_left !== 21'd4 || bus.o_tick !== 1'b0) begin errors++; $display("FAIL pt_coincide: tl %0d tick %b want 4/0", bus.o_time_left, bus.o_tick); end
    idle(3);
    checks++; if (bus.o_time_left !== 21'd4 || bus.o_tick !== 1'b0) begin errors++; $display("FAIL pt_wrap_wait: tl %0d tick %b want 4/0", bus.o_time_left, bus.o_tick); end
    idle(1);
    checks++; if (bus.o_time_left !== 21'd3 || bus.o_tick !== 1'b1 || bus.o_warn !== 1'b0) begin errors++; $display("FAIL pt_wrap_tick: tl %0d tick %b warn %b want 3/1/0", bus.o_time_left, bus.o_tick, bus.o_warn); end
    idle(4);
    checks++; if (bus.o_time_left !== 21'd2 || bus.o_warn !== 1'b1) begin errors++; $display("FAIL pt_warn_on: tl %0d warn %b want 2/1", bus.o_time_left, bus.o_warn); end
    idle(4);
    checks++; if (bus.o_time_left !== 21'd1 || bus.o_warn !== 1'b1) begin errors++; $display("FAIL pt_warn_one: tl %0d warn %b want 1/1", bus.o_time_left, bus.o_warn); end
    idle(4);
    checks++; if (bus.o_time_left !== 21'd0 || bus.o_warn !== 1'b0 || bus.o_game_over !== 1'b1) begin errors++; $display("FAIL pt_warn_off: tl %0d warn %b go %b want 0/0/1", bus.o_time_left, bus.o_warn, bus.o_game_over); end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_abort_priority;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(5);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    checks++; if (bus.o_state !== 2'd0 || bus.o_time_left !== 21'd10 || bus.o_running !== 1'b0) begin errors++; $display("FAIL ab_run: state %0d tl %0d running %b want 0/10/0", bus.o_state, bus.o_time_left, bus.o_running); end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    checks++; if (bus.o_state !== 2'd0 || bus.o_time_left !== 21'd10) begin errors++; $display("FAIL ab_pause: state %0d tl %0d want 0/10", bus.o_state, bus.o_time_left); end
  endtask

  task automatic test_reset_mid;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(20);
    checks++; if (bus.o_time_left !== 21'd5) begin errors++; $display("FAIL rm_at_five: got %0d want 5", bus.o_time_left); end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checks++; if (bus.o_state !== 2'd0 || bus.o_time_left !== 21'd10 || bus.o_running !== 1'b0 ||
                  bus.o_warn !== 1'b0 || bus.o_tick !== 1'b0 || bus.o_game_over !== 1'b0) begin
      errors++; $display("FAIL rm_reset: state %0d tl %0d run %b warn %b tick %b go %b", bus.o_state, bus.o_time_left, bus.o_running, bus.o_warn, bus.o_tick, bus.o_game_over);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.o_state !== 2'd1 || bus.o_time_left !== 21'd10) begin errors++; $display("FAIL rm_restart: state %0d tl %0d want 1/10", bus.o_state, bus.o_time_left); end
    idle(4);
    checks++; if (bus.o_time_left !== 21'd9 || bus.o_tick !== 1'b1) begin errors++; $display("FAIL rm_first_tick: tl %0d tick %b want 9/1", bus.o_time_left, bus.o_tick); end
  endtask

  task automatic test_random;
    bit st, pa, ab, pe, rs;
    bit exp_run, exp_warn;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      st = ($urandom_range(0, 99) < 20);
      pa = ($urandom_range(0, 99) < 10);
      pe = ($urandom_range(0, 99) < 4);
      ab = ($urandom_range(0, 199) < 2);
      rs = !($urandom_range(0, 199) < 1);
      drive(rs, st, pa, ab, pe);
      exp_run  = (m_state == S_RUN);
      exp_warn = exp_run && m_tl > 0 && m_tl <= WARN;
      checks++; if (bus.o_state !== 2'(m_state)) begin errors++; $display("FAIL rnd_state[%0d]: got %0d want %0d", i, bus.o_state, m_state); end
      checks++; if (bus.o_time_left !== 21'(m_tl)) begin errors++; $display("FAIL rnd_time_left[%0d]: got %0d want %0d", i, bus.o_time_left, m_tl); end
      checks++; if (bus.o_tick !== m_tick) begin errors++; $display("FAIL rnd_tick[%0d]: got %b want %b", i, bus.o_tick, m_tick); end
      checks++; if (bus.o_game_over !== m_go) begin errors++; $display("FAIL rnd_game_over[%0d]: got %b want %b", i, bus.o_game_over, m_go); end
      checks++; if (bus.o_running !== exp_run) begin errors++; $display("FAIL rnd_running[%0d]: got %b want %b", i, bus.o_running, exp_run); end
      checks++; if (bus.o_warn !== exp_warn) begin errors++; $display("FAIL rnd_warn[%0d]: got %b want %b", i, bus.o_warn, exp_warn); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    bus.i_start   = 1'b0;
    bus.i_pause   = 1'b0;
    bus.i_abort   = 1'b0;
    bus.i_penalty = 1'b0;
    test_reset();
    test_full_countdown();
    test_pause_resume();
    test_penalty_expire();
    test_penalty_tick();
    test_abort_priority();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
